// File: rtl/br_pkg.sv
// br_pkg: shared opcode, branch-class and condition-function encodings for branch resolution
package br_pkg;
  localparam logic [5:0] OP_BR        = 6'h30;
  localparam logic [5:0] OP_BSR       = 6'h34;
  localparam logic [2:0] CLS_JMP      = 3'b011;
  localparam logic [2:0] CLS_PCREL_LO = 3'b110;
  localparam logic [2:0] CLS_PCREL_HI = 3'b111;
  typedef enum logic [1:0] {
    CF_LBC = 2'b00,
    CF_EQ  = 2'b01,
    CF_LT  = 2'b10,
    CF_LE  = 2'b11
  } cond_func_e;
endpackage

// File: rtl/br_resolve_q_if.sv
// br_resolve_q_if: issue and resolved-result handshakes of the branch resolver
//   master: drives issued branches and result ready; slave: the resolver
interface br_resolve_q_if #(
  parameter int XLEN      = 64,
  parameter int ROB_IDX_W = 6
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [XLEN-1:0]      npc_i;
  logic [XLEN-1:0]      opa_i;
  logic [31:0]          inst_i;
  logic [ROB_IDX_W-1:0] rob_idx_i;
  logic                 pred_taken_i;
  logic [XLEN-1:0]      pred_target_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 br_taken_o;
  logic [XLEN-1:0]      br_target_o;
  logic                 mispred_o;
  logic [ROB_IDX_W-1:0] rob_idx_o;
  logic [XLEN-1:0]      br_pc_o;
  modport master (
    output in_valid_i, npc_i, opa_i, inst_i, rob_idx_i, pred_taken_i, pred_target_i, out_ready_i,
    input  in_ready_o, out_valid_o, br_taken_o, br_target_o, mispred_o, rob_idx_o, br_pc_o
  );
  modport slave (
    input  in_valid_i, npc_i, opa_i, inst_i, rob_idx_i, pred_taken_i, pred_target_i, out_ready_i,
    output in_ready_o, out_valid_o, br_taken_o, br_target_o, mispred_o, rob_idx_o, br_pc_o
  );
endinterface

// File: rtl/br_cond_eval.sv
// br_cond_eval: evaluates a conditional-branch predicate on register A
//   opa  : register A value
//   func : condition function, [1:0] selects the test, [2] inverts it
//   cond : predicate result
module br_cond_eval
  import br_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] opa,
  input  logic [2:0]      func,
  output logic            cond
);
  cond_func_e fn;
  logic       zero, neg, base;
  assign fn   = cond_func_e'(func[1:0]);
  assign zero = opa == '0;
  assign neg  = opa[XLEN-1];
  assign base = fn == CF_LBC ? !opa[0] : fn == CF_EQ ? zero : fn == CF_LT ? neg : neg || zero;
  assign cond = base ^ func[2];
endmodule

// File: rtl/br_resolve_q.sv
// br_resolve_q: queued branch resolver producing taken/target/mispredict per issued branch
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush_i       : squash queued entries and the held result
//   bus (slave)   : issue handshake in, registered resolved-result handshake out
//   mispred_cnt_o : saturating count of mispredicted results handed off
module br_resolve_q
  import br_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int ROB_IDX_W = 6,
  parameter int QDEPTH    = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  br_resolve_q_if.slave    bus,
  output logic [CNT_W-1:0] mispred_cnt_o
);
  localparam int AW = $clog2(QDEPTH);
  logic [XLEN-1:0]      npc_m  [QDEPTH];
  logic [XLEN-1:0]      opa_m  [QDEPTH];
  logic [XLEN-1:0]      ptgt_m [QDEPTH];
  logic [31:0]          inst_m [QDEPTH];
  logic [ROB_IDX_W-1:0] rob_m  [QDEPTH];
  logic [QDEPTH-1:0]    ptk_m;
  logic [AW:0]          wptr, rptr;
  logic [AW-1:0]        wa, ra;
  logic                 rdy_q, full, empty, push, load;
  logic [31:0]          inst;
  logic [XLEN-1:0]      npc, opa, disp, tgt;
  logic                 is_jmp, is_pcrel, is_uncond, cond, taken, mis;
  assign wa    = wptr[AW-1:0];
  assign ra    = rptr[AW-1:0];
  assign full  = wptr == {~rptr[AW], ra};
  assign empty = wptr == rptr;
  // rdy_q keeps in_ready low while in reset and until the first edge after it
  assign bus.in_ready_o = rdy_q && !full && !flush_i;
  assign push  = bus.in_valid_i && bus.in_ready_o;
  assign load  = !empty && !flush_i && (!bus.out_valid_o || bus.out_ready_i);
  assign inst  = inst_m[ra];
  assign npc   = npc_m[ra];
  assign opa   = opa_m[ra];
  assign is_jmp    = inst[31:29] == CLS_JMP;
  assign is_pcrel  = inst[31:29] == CLS_PCREL_LO || inst[31:29] == CLS_PCREL_HI;
  assign is_uncond = inst[31:26] == OP_BR || inst[31:26] == OP_BSR;
  assign disp  = {{(XLEN-23){inst[20]}}, inst[20:0], 2'b00};
  br_cond_eval #(.XLEN(XLEN)) u_cond (.opa(opa), .func(inst[28:26]), .cond(cond));
  assign taken = is_jmp || (is_pcrel && (is_uncond || cond));
  assign tgt   = is_jmp ? {opa[XLEN-1:2], 2'b00} : is_pcrel ? npc + disp : npc;
  assign mis   = taken != ptk_m[ra] || (taken && tgt != ptgt_m[ra]);
  always_ff @(posedge clk)
    if (push) begin
      npc_m[wa]  <= bus.npc_i;
      opa_m[wa]  <= bus.opa_i;
      ptgt_m[wa] <= bus.pred_target_i;
      inst_m[wa] <= bus.inst_i;
      rob_m[wa]  <= bus.rob_idx_i;
      ptk_m[wa]  <= bus.pred_taken_i;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr            <= '0;
      rptr            <= '0;
      rdy_q           <= 1'b0;
      bus.out_valid_o <= 1'b0;
      bus.br_taken_o  <= 1'b0;
      bus.mispred_o   <= 1'b0;
      bus.br_target_o <= '0;
      bus.br_pc_o     <= '0;
      bus.rob_idx_o   <= '0;
      mispred_cnt_o   <= '0;
    end else begin
      rdy_q <= 1'b1;
      // a handshake on a flushing edge still counts
      if (bus.out_valid_o && bus.out_ready_i && bus.mispred_o && !(&mispred_cnt_o))
        mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
      if (flush_i) begin
        wptr            <= '0;
        rptr            <= '0;
        bus.out_valid_o <= 1'b0;
      end else begin
        if (push) wptr <= wptr + (AW+1)'(1);
        if (load || bus.out_ready_i) bus.out_valid_o <= load;
        if (load) begin
          rptr            <= rptr + (AW+1)'(1);
          bus.br_taken_o  <= taken;
          bus.br_target_o <= tgt;
          bus.mispred_o   <= mis;
          bus.rob_idx_o   <= rob_m[ra];
          bus.br_pc_o     <= npc;
        end
      end
    end
endmodule
